// File: rtl/duram_frame_reader.sv
// duram_frame_reader: port-B read controller for one duram frame buffer.
// Issues reads ahead of the consumer, absorbs the RAM's 1-cycle read latency
// in a 2-entry skid buffer and offers words as a valid/ready stream.
// Default build is store-and-forward: words leave only while at least one
// committed frame is pending. Define DURAM_RD_CUT_THROUGH_EN to stream words
// as soon as they land in the buffer (frame_wr_done ignored, frame_cnt = 0).
module duram_frame_reader #(
  parameter int unsigned DATA_WIDTH      = 36,
  parameter int unsigned ADDR_WIDTH      = 9,
  parameter int unsigned FRAME_CNT_WIDTH = 6
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [ADDR_WIDTH:0]        wr_ptr,
  input  logic                       frame_wr_done,
  output logic [ADDR_WIDTH:0]        rd_ptr,
  output logic [ADDR_WIDTH-1:0]      ram_address_b,
  output logic                       ram_wren_b,
  input  logic [DATA_WIDTH-1:0]      ram_q_b,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
);

  localparam int unsigned EopBit = 33;

  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                  inflight_q;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic                  head_q, head_d;
  logic                  tail;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  avail, issue, pop, gate;
  logic [2:0]            occ;

  // Read issue, skid-buffer bookkeeping and pointer advance.
  always_comb begin
    avail     = (wr_ptr != rd_ptr_q);
    pop       = out_valid & out_ready;
    // Occupancy once this cycle's return and pop are accounted for; a new read
    // may only go out if its word is guaranteed a slot when it returns.
    occ       = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = avail & (occ < 3'd2);
    tail      = head_q ^ buf_cnt_q[0];
    head_d    = head_q ^ pop;
    buf_cnt_d = occ[1:0];
    rd_ptr_d  = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, issue};
  end

  // Pointer, in-flight flag and skid-buffer storage.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      head_q     <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= issue;
      buf_cnt_q  <= buf_cnt_d;
      head_q     <= head_d;
      // Word addressed last cycle is on ram_q_b now.
      if (inflight_q) begin
        buf_q[tail] <= ram_q_b;
      end
    end
  end

`ifdef DURAM_RD_CUT_THROUGH_EN
  logic unused_frame_wr_done;

  assign unused_frame_wr_done = frame_wr_done;
  assign gate                 = 1'b1;
  assign frame_cnt            = '0;
`else
  localparam logic [FRAME_CNT_WIDTH-1:0] CntOne = FRAME_CNT_WIDTH'(1);

  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                       eop_pop;

  // Committed-frame count: up on commit, down on eop pop, saturating at max.
  always_comb begin
    eop_pop     = pop & buf_q[head_q][EopBit];
    frame_cnt_d = frame_cnt_q;
    if (frame_wr_done && !eop_pop) begin
      if (frame_cnt_q != '1) begin
        frame_cnt_d = frame_cnt_q + CntOne;
      end
    end else if (!frame_wr_done && eop_pop) begin
      frame_cnt_d = frame_cnt_q - CntOne;
    end
  end

  // Committed-frame count register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign gate      = (frame_cnt_q != '0);
  assign frame_cnt = frame_cnt_q;
`endif

  // Outputs are forced quiet while reset is held.
  always_comb begin
    out_valid     = !Reset && (buf_cnt_q != 2'd0) && gate;
    out_data      = Reset ? '0 : buf_q[head_q];
    rd_ptr        = rd_ptr_q;
    ram_address_b = rd_ptr_q[ADDR_WIDTH-1:0];
    ram_wren_b    = 1'b0;
  end

endmodule
